product_accumulator: RTL and testbench

Streaming accumulator directly downstream of the 64x64 Karatsuba multiplier. It takes 128-bit products over a valid/ready handshake and sums a group of them, up to MAXN products, into a guarded accumulator. It then presents the group sum, product count and a forced-flush flag on a registered valid/ready output. It turns the combinational multiplier into a dot-product / multiply-accumulate datapath.

---
 rtl/karatsuba_pkg.sv | 23 ++
 rtl/product_accumulator_if.sv | 25 ++
 rtl/product_accumulator.sv | 91 +++++++++
 tb/tb_product_accumulator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared parameters and types for the product accumulator that sits behind the
// 64x64 Karatsuba multiplier.
package karatsuba_pkg;

  localparam int unsigned PW   = 128;
  localparam int unsigned GW   = 8;
  localparam int unsigned MAXN = 256;
  localparam int unsigned AW   = PW + GW;
  localparam int unsigned CW   = $clog2(MAXN) + 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Group result held while presented to the consumer
  typedef struct packed {
    logic [AW-1:0] sum;
    logic [CW-1:0] count;
    logic          forced;
  } result_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream and group-result output stream of the accumulator.
interface product_accumulator_if;
  import karatsuba_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_forced;

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_forced
  );

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_forced
  );

endinterface

// File: rtl/product_accumulator.sv
// Sums groups of up to MAXN multiplier products into a guarded accumulator and
// presents each group sum, count and forced-flush flag on a registered output.
module product_accumulator
  import karatsuba_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  product_accumulator_if.slave  bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  result_t       r_res;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;
  logic          w_close;
  logic [AW-1:0] w_sum_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Guard bits must absorb MAXN full-scale products without wrapping
  if (MAXN > (2 ** GW)) begin : g_bad_maxn
    $error("MAXN exceeds guard-bit capacity");
  end

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_sum_nxt = r_acc + AW'(bus.in_prod);
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_close   = bus.in_last | (w_cnt_nxt == CW'(MAXN));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_accept && w_close) w_state_nxt = HOLD;
      HOLD:    if (bus.out_ready)       w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  // Handshake outputs; in_ready deliberately ignores in_valid
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ACC:     w_in_ready  = ~clr;
      HOLD:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulator and result registers; clr is ignored in HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else if (r_state == ACC) begin
      if (clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_close) begin
          r_res <= '{sum: w_sum_nxt, count: w_cnt_nxt, forced: ~bus.in_last};
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum_nxt;
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_sum    = r_res.sum;
  assign bus.out_count  = r_res.count;
  assign bus.out_forced = r_res.forced;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: vector table, directed corner
// sequences and a randomized run against a queue-based group-sum model.
module tb_product_accumulator;
  import karatsuba_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  product_accumulator_if bus ();

  product_accumulator dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [PW-1:0] prod;
    logic          last;
    logic [AW-1:0] exp_sum;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_prod  = '0;
  endtask

  logic [PW-1:0] ones;
  logic [AW-1:0] exp_flush;

  // Randomized model state
  logic [PW-1:0] grp[$];
  bit            m_hold;
  logic [AW-1:0] m_sum;
  int            m_cnt;
  bit            m_forced;

  initial begin
    ones      = '1;
    exp_flush = ~AW'(0) - AW'(255);

    vecs[0] = '{prod: PW'(5), last: 1'b0, exp_sum: '0, exp_cnt: 0};
    vecs[1] = '{prod: PW'(7), last: 1'b0, exp_sum: '0, exp_cnt: 0};
    vecs[2] = '{prod: ones,   last: 1'b1, exp_sum: (AW'(1) << 128) + AW'(11), exp_cnt: 3};
    vecs[3] = '{prod: PW'(0), last: 1'b1, exp_sum: AW'(0), exp_cnt: 1};
    vecs[4] = '{prod: PW'(1) << 127, last: 1'b0, exp_sum: '0, exp_cnt: 0};
    vecs[5] = '{prod: PW'(1) << 127, last: 1'b1, exp_sum: AW'(1) << 128, exp_cnt: 2};

    idle();
    bus.out_ready = 1'b1;

    // Reset values
    #2;
    chk("rst_out_valid", AW'(bus.out_valid), AW'(0));
    chk("rst_in_ready", AW'(bus.in_ready), AW'(1));
    chk("rst_out_sum", bus.out_sum, AW'(0));
    chk("rst_out_count", AW'(bus.out_count), AW'(0));
    chk("rst_out_forced", AW'(bus.out_forced), AW'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Vector table: groups with out_ready held high
    foreach (vecs[i]) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = vecs[i].prod;
      bus.in_last  = vecs[i].last;
      chk("tbl_in_ready", AW'(bus.in_ready), AW'(1));
      tick();
      if (vecs[i].last) begin
        idle();
        chk("tbl_valid", AW'(bus.out_valid), AW'(1));
        chk("tbl_sum", bus.out_sum, vecs[i].exp_sum);
        chk("tbl_count", AW'(bus.out_count), AW'(vecs[i].exp_cnt));
        chk("tbl_forced", AW'(bus.out_forced), AW'(0));
        chk("tbl_hold_ready", AW'(bus.in_ready), AW'(0));
        tick();
        chk("tbl_valid_drop", AW'(bus.out_valid), AW'(0));
      end else begin
        chk("tbl_no_valid", AW'(bus.out_valid), AW'(0));
      end
    end

    // Forced flush after MAXN products without in_last
    bus.out_ready = 1'b0;
    for (int i = 0; i < int'(MAXN); i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = ones;
      bus.in_last  = 1'b0;
      if (bus.in_ready !== 1'b1) chk("flush_in_ready", AW'(bus.in_ready), AW'(1));
      tick();
    end
    chk("flush_valid", AW'(bus.out_valid), AW'(1));
    chk("flush_sum", bus.out_sum, exp_flush);
    chk("flush_count", AW'(bus.out_count), AW'(MAXN));
    chk("flush_forced", AW'(bus.out_forced), AW'(1));
    for (int i = 0; i < 3; i++) begin
      chk("flush_hold_ready", AW'(bus.in_ready), AW'(0));
      tick();
    end
    idle();
    bus.out_ready = 1'b1;
    tick();
    chk("flush_released", AW'(bus.out_valid), AW'(0));

    // Backpressure: result stable while out_ready low, next product waits
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_prod   = PW'(32'hDEAD);
    bus.in_last   = 1'b1;
    tick();
    bus.in_prod = PW'(32'h1234);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", AW'(bus.out_valid), AW'(1));
      chk("bp_sum", bus.out_sum, AW'(32'hDEAD));
      chk("bp_in_ready", AW'(bus.in_ready), AW'(0));
      if (i == 5) bus.out_ready = 1'b1;
      tick();
    end
    chk("bp_release_valid", AW'(bus.out_valid), AW'(0));
    chk("bp_release_ready", AW'(bus.in_ready), AW'(1));
    tick();
    idle();
    chk("bp_next_valid", AW'(bus.out_valid), AW'(1));
    chk("bp_next_sum", bus.out_sum, AW'(32'h1234));
    chk("bp_next_count", AW'(bus.out_count), AW'(1));
    tick();

    // clr mid-group discards partial sum and blocks the concurrent product
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(100);
    tick();
    bus.in_prod = PW'(200);
    tick();
    clr = 1'b1;
    bus.in_prod = PW'(50);
    #1;
    chk("clr_in_ready", AW'(bus.in_ready), AW'(0));
    tick();
    clr = 1'b0;
    bus.in_prod = PW'(9);
    bus.in_last = 1'b1;
    tick();
    idle();
    chk("clr_sum", bus.out_sum, AW'(9));
    chk("clr_count", AW'(bus.out_count), AW'(1));
    tick();

    // Asynchronous reset while a result is held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_prod   = PW'(32'h55);
    bus.in_last   = 1'b1;
    tick();
    idle();
    chk("hold_before_rst", AW'(bus.out_valid), AW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_hold_valid", AW'(bus.out_valid), AW'(0));
    chk("rst_hold_sum", bus.out_sum, AW'(0));
    chk("rst_hold_count", AW'(bus.out_count), AW'(0));
    chk("rst_hold_forced", AW'(bus.out_forced), AW'(0));
    chk("rst_hold_ready", AW'(bus.in_ready), AW'(1));
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_prod   = PW'(3);
    tick();
    bus.in_prod = PW'(4);
    bus.in_last = 1'b1;
    tick();
    idle();
    chk("post_rst_sum", bus.out_sum, AW'(7));
    chk("post_rst_count", AW'(bus.out_count), AW'(2));
    tick();

    // Randomized products from 64x64 operands against a group-sum model
    m_hold = 1'b0;
    grp.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [63:0]   a;
      logic [63:0]   b;
      logic [PW-1:0] p;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '1;
      p = PW'(a) * PW'(b);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_prod   = p;
      bus.in_last   = ($urandom_range(0, 5) == 0);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      clr           = ($urandom_range(0, 31) == 0);
      #1;
      chk("rnd_in_ready", AW'(bus.in_ready), AW'(!m_hold && !clr));
      chk("rnd_valid", AW'(bus.out_valid), AW'(m_hold));
      if (m_hold) begin
        chk("rnd_sum", bus.out_sum, m_sum);
        chk("rnd_count", AW'(bus.out_count), AW'(m_cnt));
        chk("rnd_forced", AW'(bus.out_forced), AW'(m_forced));
      end
      if (m_hold) begin
        if (bus.out_ready) m_hold = 1'b0;
      end else if (clr) begin
        grp.delete();
      end else if (bus.in_valid) begin
        grp.push_back(p);
        if (bus.in_last || grp.size() == int'(MAXN)) begin
          m_sum = '0;
          foreach (grp[k]) m_sum = m_sum + AW'(grp[k]);
          m_cnt    = grp.size();
          m_forced = !bus.in_last;
          m_hold   = 1'b1;
          grp.delete();
        end
      end
      tick();
    end
    clr = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
